// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction inputs, memory handshake, datapath strobes and status of the control sequencer.
interface control_sequencer_if;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable;
  logic        Y_enable, Z_enable, ZLow_out, ZHigh_out, LO_enable, HI_enable;
  logic [15:0] reg_out_sel, reg_en_sel;
  logic [4:0]  opcode;
  logic        busy, done, illegal;
  modport master (
    output start, ir, mem_ready,
    input  PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable,
    input  Y_enable, Z_enable, ZLow_out, ZHigh_out, LO_enable, HI_enable,
    input  reg_out_sel, reg_en_sel, opcode, busy, done, illegal
  );
  modport slave (
    input  start, ir, mem_ready,
    output PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable,
    output Y_enable, Z_enable, ZLow_out, ZHigh_out, LO_enable, HI_enable,
    output reg_out_sel, reg_en_sel, opcode, busy, done, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute FSM driving datapath strobes for three-register ALU instructions.
// Define SEQ_MULDIV_EN to add mul/div, which use a T6 state and the LO/HI registers.
module control_sequencer (
  input logic clk,
  input logic clr,
  control_sequencer_if.slave bus
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
  state_t r_state, w_next;
  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_md, w_legal;
  assign w_op = bus.ir[31:27];
  assign w_ra = bus.ir[26:23];
  assign w_rb = bus.ir[22:19];
  assign w_rc = bus.ir[18:15];
`ifdef SEQ_MULDIV_EN
  assign w_md = (w_op == 5'b01111) || (w_op == 5'b10000);
`else
  assign w_md = 1'b0;
`endif
  assign w_legal = (w_op >= 5'b00011 && w_op <= 5'b01011) || w_md;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? T0 : IDLE;
      T0:      w_next = T1;
      T1:      w_next = bus.mem_ready ? T2 : T1;
      T2:      w_next = T3;
      T3:      w_next = w_legal ? T4 : HALT;
      T4:      w_next = T5;
      T5:      w_next = w_md ? T6 : (bus.start ? T0 : IDLE);
      T6:      w_next = bus.start ? T0 : IDLE;
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end
  // Outputs depend only on r_state and ir, so clr clears them without waiting for a clock.
  always_comb begin
    bus.PC_out      = 1'b0;
    bus.MAR_enable  = 1'b0;
    bus.IncPC       = 1'b0;
    bus.PC_enable   = 1'b0;
    bus.Read        = 1'b0;
    bus.MDR_enable  = 1'b0;
    bus.MDR_out     = 1'b0;
    bus.IR_enable   = 1'b0;
    bus.Y_enable    = 1'b0;
    bus.Z_enable    = 1'b0;
    bus.ZLow_out    = 1'b0;
    bus.ZHigh_out   = 1'b0;
    bus.LO_enable   = 1'b0;
    bus.HI_enable   = 1'b0;
    bus.reg_out_sel = 16'd0;
    bus.reg_en_sel  = 16'd0;
    bus.opcode      = 5'd0;
    bus.done        = 1'b0;
    bus.illegal     = r_state == HALT;
    bus.busy        = r_state != IDLE && r_state != HALT;
    case (r_state)
      T0: begin
        bus.PC_out     = 1'b1;
        bus.MAR_enable = 1'b1;
        bus.IncPC      = 1'b1;
        bus.PC_enable  = 1'b1;
      end
      T1: begin
        bus.Read       = 1'b1;
        bus.MDR_enable = 1'b1;
      end
      T2: begin
        bus.MDR_out    = 1'b1;
        bus.IR_enable  = 1'b1;
      end
      T3: begin
        bus.Y_enable    = w_legal;
        bus.reg_out_sel = w_legal ? 16'd1 << (w_md ? w_ra : w_rb) : 16'd0;
      end
      T4: begin
        bus.Z_enable    = 1'b1;
        bus.opcode      = w_op;
        bus.reg_out_sel = 16'd1 << (w_md ? w_rb : w_rc);
      end
      T5: begin
        bus.ZLow_out   = 1'b1;
        bus.reg_en_sel = w_md ? 16'd0 : 16'd1 << w_ra;
        bus.done       = !w_md;
`ifdef SEQ_MULDIV_EN
        bus.LO_enable  = w_md;
`endif
      end
`ifdef SEQ_MULDIV_EN
      T6: begin
        bus.ZHigh_out = 1'b1;
        bus.HI_enable = 1'b1;
        bus.done      = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to execute the next instruction.
REQ-004 SHALL have port ir, input, 32, IR contents: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-005 SHALL have port mem_ready, input, 1, memory read data valid on Mdatain.
REQ-006 SHALL have ports PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable, Y_enable, Z_enable, ZLow_out, ZHigh_out, LO_enable, HI_enable, output, 1 each, datapath strobes.
REQ-007 SHALL have ports reg_out_sel and reg_en_sel, output, 16 each, one-hot R0..R15 bus-drive and load selects.
REQ-008 SHALL have port opcode, output, 5, ALU operation.
REQ-009 SHALL have ports busy, done and illegal, output, 1 each, status.

Function
REQ-010 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6 and HALT; outputs SHALL be decoded from present state and ir only, with no combinational path from start or mem_ready.
REQ-011 IDLE: all outputs 0; start=1 at a rising edge -> T0.
REQ-012 T0: PC_out, MAR_enable, IncPC, PC_enable = 1; -> T1.
REQ-013 T1: Read, MDR_enable = 1; remain in T1 while mem_ready=0; mem_ready=1 -> T2.
REQ-014 T2: MDR_out, IR_enable = 1; -> T3.
REQ-015 T3: legal three-register opcodes are 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol. In T3, reg_out_sel = onehot(Rb) and Y_enable = 1; -> T4.
REQ-016 Illegal opcode in T3 -> HALT; no strobe asserted in that cycle.
REQ-017 T4 (three-register): reg_out_sel = onehot(Rc), opcode = ir[31:27], Z_enable = 1; -> T5.
REQ-018 T5 (three-register): ZLow_out = 1, reg_en_sel = onehot(Ra), done = 1; -> T0 if start=1, else IDLE.
REQ-019 busy = 1 in T0..T6; done is a single-cycle pulse in the final execute state.
REQ-020 HALT: illegal = 1, all other outputs 0, start ignored; exit only via clr.
REQ-021 No more than one bit of reg_out_sel or reg_en_sel SHALL be set in any cycle; ir is sampled only in T3..T6.

Reset
REQ-022 clr=1 SHALL force IDLE and all outputs to 0 immediately, regardless of clock, including mid-instruction and in HALT.
REQ-023 Upon clr deassertion, the first transition SHALL occur at the next rising edge with start=1.

Configuration
REQ-024 Macro SEQ_MULDIV_EN defined: opcodes 01111 mul and 10000 div are legal, with the following sequence:
- T3: reg_out_sel = onehot(Ra), Y_enable.
- T4: reg_out_sel = onehot(Rb), opcode, Z_enable.
- T5: ZLow_out, LO_enable.
- T6: ZHigh_out, HI_enable, done.
T6 exits per REQ-018.
REQ-025 Macro SEQ_MULDIV_EN undefined: 01111 and 10000 are illegal per REQ-016; T6, LO_enable and HI_enable SHALL be constant 0.

Verification
REQ-026 and R1,R2,R3: ir=0x28918000, mem_ready=1, start pulsed 1 cycle -> T0..T5 one cycle each, with:
- T3: reg_out_sel=0x0004, Y_enable.
- T4: reg_out_sel=0x0008, opcode=00101, Z_enable.
- T5: ZLow_out, reg_en_sel=0x0002, done.
- busy high for 6 cycles, then IDLE.
REQ-027 Memory stall: mem_ready=0 for the first 3 T1 cycles -> Read and MDR_enable held 4 cycles; instruction completes in 9 cycles.
REQ-028 Illegal: ir[31:27]=11111 -> HALT after T3, illegal=1, no enables for 10 cycles with start=1; clr -> IDLE, illegal=0.
REQ-029 mul R4,R5 (ir=0x7A280000) with SEQ_MULDIV_EN:
- T3: reg_out_sel=0x0010.
- T4: reg_out_sel=0x0020, opcode=01111.
- T5: LO_enable.
- T6: HI_enable, done.
Without SEQ_MULDIV_EN -> HALT.
REQ-030 clr asserted mid-T4 between edges -> Z_enable and reg_out_sel drop to 0 immediately, state IDLE; start=1 afterwards resumes at T0.
REQ-031 start held 1 -> back-to-back instructions, T5 followed directly by T0, done every 6 cycles.
